mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/mod_counter.sv | 98 +++++++++
 tb/tb_mod_counter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - Prescaled up/down modulo counter with load, terminal count and wrap pulse
//
// Parameters:
//   BUS_WIDTH  width of load value and count (1..32)
//   MODULUS    count range 0..MODULUS-1 (2..2**BUS_WIDTH)
//   SATURATE   0 = wrap at range ends, 1 = hold at range ends
//   PRESCALE   enabled cycles per count step (1..65535)
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   en     count enable, feeds the prescaler
//   ld     parallel load strobe (beats en)
//   X      parallel load value, clamped to MODULUS-1
//   up     direction, 1 = increment, 0 = decrement
//   o      registered count value
//   tc     terminal count for the current direction (combinational)
//   ovf    one-cycle pulse after a step taken at a range end
module mod_counter #(
    parameter int    BUS_WIDTH = 8,
    parameter longint MODULUS  = 256,
    parameter int    SATURATE  = 0,
    parameter int    PRESCALE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 ld,
    input  logic [BUS_WIDTH-1:0] X,
    input  logic                 up,
    output logic [BUS_WIDTH-1:0] o,
    output logic                 tc,
    output logic                 ovf
);

    localparam logic [BUS_WIDTH-1:0] MAX_VAL   = BUS_WIDTH'(MODULUS - 1);
    localparam logic [15:0]          PCNT_LAST = 16'(PRESCALE - 1);
    // When the range covers every code of the bus, no load value can exceed it.
    localparam bit                   FULL_RANGE = (MODULUS == (64'd1 << BUS_WIDTH));

    logic [15:0]          pcnt;
    logic [BUS_WIDTH-1:0] load_val;
    logic                 at_top;
    logic                 at_bottom;

    generate
        if (FULL_RANGE) begin : g_full
            assign load_val = X;
        end else begin : g_clamp
            assign load_val = (X > MAX_VAL) ? MAX_VAL : X;
        end
    endgenerate

    assign at_top    = (o == MAX_VAL);
    assign at_bottom = (o == '0);
    assign tc        = up ? at_top : at_bottom;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o    <= '0;
            pcnt <= '0;
            ovf  <= 1'b0;
        end else if (ld) begin
            o    <= load_val;
            pcnt <= '0;
            ovf  <= 1'b0;
        end else if (en) begin
            ovf <= 1'b0;
            if (pcnt == PCNT_LAST) begin
                // Step cycle: direction is sampled only here.
                pcnt <= '0;
                if (up) begin
                    if (at_top) begin
                        ovf <= 1'b1;
                        if (SATURATE == 0) begin
                            o <= '0;
                        end
                    end else begin
                        o <= o + 1'b1;
                    end
                end else begin
                    if (at_bottom) begin
                        ovf <= 1'b1;
                        if (SATURATE == 0) begin
                            o <= MAX_VAL;
                        end
                    end else begin
                        o <= o - 1'b1;
                    end
                end
            end else begin
                pcnt <= pcnt + 16'd1;
            end
        end else begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - Self-checking bench for mod_counter across four configurations
module tb_mod_counter;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       ld    = 1'b0;
    logic       up    = 1'b1;
    logic [7:0] x     = 8'd0;

    logic [3:0] o_a, o_c;
    logic [7:0] o_b;
    logic [2:0] o_d;
    logic       tc_a, tc_b, tc_c, tc_d;
    logic       ovf_a, ovf_b, ovf_c, ovf_d;

    // A: wrap mod 10; B: full-range saturating; C: saturating mod 10 prescale 3; D: full-range wrap prescale 2
    mod_counter #(.BUS_WIDTH(4), .MODULUS(10),  .SATURATE(0), .PRESCALE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .X(x[3:0]), .up(up), .o(o_a), .tc(tc_a), .ovf(ovf_a));
    mod_counter #(.BUS_WIDTH(8), .MODULUS(256), .SATURATE(1), .PRESCALE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .X(x),      .up(up), .o(o_b), .tc(tc_b), .ovf(ovf_b));
    mod_counter #(.BUS_WIDTH(4), .MODULUS(10),  .SATURATE(1), .PRESCALE(3)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .X(x[3:0]), .up(up), .o(o_c), .tc(tc_c), .ovf(ovf_c));
    mod_counter #(.BUS_WIDTH(3), .MODULUS(8),   .SATURATE(0), .PRESCALE(2)) u_d (
        .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .X(x[2:0]), .up(up), .o(o_d), .tc(tc_d), .ovf(ovf_d));

    int cfg_bw  [NI] = '{4, 8, 4, 3};
    int cfg_mod [NI] = '{10, 256, 10, 8};
    int cfg_sat [NI] = '{0, 1, 1, 0};
    int cfg_ps  [NI] = '{1, 1, 3, 2};

    int m_o   [NI] = '{0, 0, 0, 0};
    int m_p   [NI] = '{0, 0, 0, 0};
    int m_ovf [NI] = '{0, 0, 0, 0};

    int checks = 0;
    int fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_o(input int i);
        case (i)
            0:       return {28'd0, o_a};
            1:       return {24'd0, o_b};
            2:       return {28'd0, o_c};
            default: return {29'd0, o_d};
        endcase
    endfunction

    function automatic logic [31:0] dut_tc(input int i);
        case (i)
            0:       return {31'd0, tc_a};
            1:       return {31'd0, tc_b};
            2:       return {31'd0, tc_c};
            default: return {31'd0, tc_d};
        endcase
    endfunction

    function automatic logic [31:0] dut_ovf(input int i);
        case (i)
            0:       return {31'd0, ovf_a};
            1:       return {31'd0, ovf_b};
            2:       return {31'd0, ovf_c};
            default: return {31'd0, ovf_d};
        endcase
    endfunction

    // Behavioural reference: integer arithmetic, range-end detected by leaving 0..MODULUS-1.
    task automatic model_update();
        int xv, n;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_o[i] = 0; m_p[i] = 0; m_ovf[i] = 0;
            end else if (ld) begin
                xv = int'(x) % (1 << cfg_bw[i]);
                m_o[i]   = (xv > cfg_mod[i] - 1) ? cfg_mod[i] - 1 : xv;
                m_p[i]   = 0;
                m_ovf[i] = 0;
            end else if (en) begin
                m_ovf[i] = 0;
                if (m_p[i] == cfg_ps[i] - 1) begin
                    m_p[i] = 0;
                    n = up ? m_o[i] + 1 : m_o[i] - 1;
                    if (n < 0 || n >= cfg_mod[i]) begin
                        m_ovf[i] = 1;
                        if (cfg_sat[i] == 0) m_o[i] = (n + cfg_mod[i]) % cfg_mod[i];
                    end else begin
                        m_o[i] = n;
                    end
                end else begin
                    m_p[i] = m_p[i] + 1;
                end
            end else begin
                m_ovf[i] = 0;
            end
        end
    endtask

    task automatic check_tc();
        int exp;
        for (int i = 0; i < NI; i++) begin
            exp = up ? int'(m_o[i] == cfg_mod[i] - 1) : int'(m_o[i] == 0);
            check_eq($sformatf("tc[%0d]", i), dut_tc(i), exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("o[%0d]", i),   dut_o(i),   m_o[i]);
            check_eq($sformatf("ovf[%0d]", i), dut_ovf(i), m_ovf[i]);
        end
        check_tc();
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ld = 1'b0; en = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0; en = 1'b1; ld = 1'b1; x = 8'd7;
        cycle();
        cycle();
        check_eq("reset_o_a", dut_o(0), 0);
        check_eq("reset_o_b", dut_o(1), 0);
        check_eq("reset_ovf_a", dut_ovf(0), 0);

        // Wrapping up-count over the decimal range
        rst_n = 1'b1; ld = 1'b0; up = 1'b1; en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            check_eq($sformatf("seq34_o_%0d", k),   dut_o(0),   (k + 1) % 10);
            check_eq($sformatf("seq34_ovf_%0d", k), dut_ovf(0), (k == 9) ? 1 : 0);
            check_eq($sformatf("seq34_tc_%0d", k),  dut_tc(0),  (k == 8) ? 1 : 0);
        end

        // Down-count wraps 0 -> 9 with a pulse; over-range load clamps
        do_reset();
        up = 1'b0; en = 1'b1;
        cycle();
        check_eq("seq35_o_first",   dut_o(0),   9);
        check_eq("seq35_ovf_first", dut_ovf(0), 1);
        cycle();
        check_eq("seq35_o_second",   dut_o(0),   8);
        check_eq("seq35_ovf_second", dut_ovf(0), 0);
        ld = 1'b1; x = 8'd12;
        cycle();
        check_eq("seq35_clamp", dut_o(0), 9);

        // Full-range saturating counter held at the top
        x = 8'd254; up = 1'b1;
        cycle();
        ld = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_eq($sformatf("seq36_o_%0d", k),   dut_o(1),   255);
            check_eq($sformatf("seq36_ovf_%0d", k), dut_ovf(1), (k >= 1) ? 1 : 0);
        end

        // Prescaled stepping and en gaps
        do_reset();
        up = 1'b1; en = 1'b1;
        cycle(); cycle();
        check_eq("seq37_before_step", dut_o(2), 0);
        cycle();
        check_eq("seq37_step1", dut_o(2), 1);
        cycle();
        en = 1'b0;
        cycle(); cycle();
        en = 1'b1;
        cycle();
        check_eq("seq37_delayed", dut_o(2), 1);
        cycle();
        check_eq("seq37_step2", dut_o(2), 2);

        // Load beats a pending step and clears the prescaler
        cycle(); cycle();
        ld = 1'b1; x = 8'd5;
        cycle();
        check_eq("seq38_load", dut_o(2), 5);
        check_eq("seq38_ovf",  dut_ovf(2), 0);
        ld = 1'b0;
        cycle(); cycle();
        check_eq("seq38_no_step_yet", dut_o(2), 5);
        cycle();
        check_eq("seq38_step", dut_o(2), 6);

        // Reset beats load; then down from zero wraps with a pulse
        ld = 1'b1; x = 8'd7;
        cycle();
        check_eq("seq39_loaded", dut_o(0), 7);
        rst_n = 1'b0;
        cycle();
        check_eq("seq39_reset_o",   dut_o(0),   0);
        check_eq("seq39_reset_ovf", dut_ovf(0), 0);
        rst_n = 1'b1; ld = 1'b0; up = 1'b0; en = 1'b1;
        cycle();
        check_eq("seq39_wrap_o",   dut_o(0),   9);
        check_eq("seq39_wrap_ovf", dut_ovf(0), 1);

        // Randomised traffic; tc is also checked right after a direction change
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            ld    = ($urandom_range(0, 19) == 0);
            en    = ($urandom_range(0, 3) != 0);
            x     = 8'($urandom_range(0, 255));
            up    = ($urandom_range(0, 7) != 0) ? up : ~up;
            #1;
            check_tc();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
